dlfloat_pair_loader: RTL and testbench

Upstream feeder for the DLFloat MAC. It accepts a stream of 16-bit DLFloat words over a valid/ready handshake and pairs consecutive words into (A, B) operand pairs. Each operand is sanitised (flush-to-zero, special-value flag), and the pairs are buffered in a small FIFO. The FIFO presents pairs to the MAC with a valid/ready handshake and a per-pair last tag that marks the end of a dot-product vector.

---
 rtl/dlfloat_pkg.sv | 40 ++++
 rtl/dlfloat_pair_fifo.sv | 60 ++++++
 rtl/dlfloat_pair_loader.sv | 124 ++++++++++++
 tb/tb_dlfloat_pair_loader.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlfloat_pkg.sv
// DLFloat shared types and helpers for the MAC feeder path.
// Word layout: sign, 6-bit exponent (bias 31), 9-bit mantissa.
package dlfloat_pkg;

  localparam int EXP_W = 6;
  localparam int MAN_W = 9;
  localparam int BIAS  = 31;

  localparam logic [15:0] DLF_ZERO        = 16'h0000;
  localparam logic [14:0] DLF_SPECIAL_MAG = 15'h7FFF;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] mant;
  } dlf_t;

  typedef struct packed {
    dlf_t a;
    dlf_t b;
    logic last;
    logic special;
  } pair_t;

  typedef enum logic {
    S_A = 1'b0,
    S_B = 1'b1
  } ld_state_t;

  function automatic dlf_t dlf_ftz(input dlf_t w);
    if (w.exp == '0)
      return dlf_t'(DLF_ZERO);
    return w;
  endfunction

  function automatic logic dlf_is_special(input dlf_t w);
    return {w.exp, w.mant} == DLF_SPECIAL_MAG;
  endfunction

endpackage

// File: rtl/dlfloat_pair_fifo.sv
// First-word fall-through FIFO of operand pairs.
// The head is forced to zero whenever the FIFO is empty.
module dlfloat_pair_fifo
  import dlfloat_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  pair_t            push_data,
  input  logic             pop,
  output pair_t            head,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH-1);

  pair_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign valid  = (count != '0);
  assign do_pop = pop & valid;
  assign head   = valid ? mem[rd_ptr] : '0;

  function automatic logic [PTR_W-1:0] nxt(
    input logic [PTR_W-1:0] p
  );
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= nxt(wr_ptr);
      if (do_pop)
        rd_ptr <= nxt(rd_ptr);
      unique case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dlfloat_pair_loader.sv
// Pairs a DLFloat word stream into sanitised (A, B) operands
// and buffers them for the MAC.
module dlfloat_pair_loader
  import dlfloat_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH+1),
  parameter int FTZ   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  input  logic             in_flush,
  output logic             pair_valid,
  input  logic             pair_ready,
  output logic [15:0]      pair_a,
  output logic [15:0]      pair_b,
  output logic             pair_last,
  output logic             pair_special,
  output logic [CNT_W-1:0] fifo_count,
  output logic             err_odd
);

  ld_state_t state, state_nxt;
  dlf_t      a_hold;
  dlf_t      san;
  pair_t     push_data;
  pair_t     head;
  logic      accept;
  logic      push;
  logic      a_load;
  logic      odd_set;
  logic      room;

  assign san = (FTZ != 0) ? dlf_ftz(dlf_t'(in_data))
                          : dlf_t'(in_data);

  // Same-cycle pop frees a slot for the B word.
  assign room = (fifo_count < CNT_W'(DEPTH))
              | (pair_valid & pair_ready);

  assign push_data = '{
    a:       a_hold,
    b:       san,
    last:    in_last,
    special: dlf_is_special(a_hold) | dlf_is_special(san)
  };

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= S_A;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (in_flush)
      state_nxt = S_A;
    else
      unique case (state)
        S_A: if (accept & !in_last) state_nxt = S_B;
        S_B: if (accept)            state_nxt = S_A;
        default:                    state_nxt = S_A;
      endcase
  end

  always_comb begin
    in_ready = 1'b0;
    push     = 1'b0;
    a_load   = 1'b0;
    odd_set  = 1'b0;
    unique case (state)
      S_A: in_ready = rst & !in_flush;
      S_B: in_ready = rst & !in_flush & room;
      default: in_ready = 1'b0;
    endcase
    accept = in_valid & in_ready;
    unique case (state)
      S_A: begin
        a_load  = accept & !in_last;
        odd_set = accept & in_last;
      end
      S_B: push = accept;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_hold  <= '0;
      err_odd <= 1'b0;
    end else begin
      err_odd <= odd_set;
      if (in_flush)
        a_hold <= '0;
      else if (a_load)
        a_hold <= san;
    end
  end

  dlfloat_pair_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pair_ready),
    .head      (head),
    .valid     (pair_valid),
    .count     (fifo_count)
  );

  assign pair_a       = head.a;
  assign pair_b       = head.b;
  assign pair_last    = head.last;
  assign pair_special = head.special;

endmodule

// File: tb/tb_dlfloat_pair_loader.sv
// Directed bench for the DLFloat pair loader.
// Inputs change 1ns after the rising edge; outputs checked there too.
module tb_dlfloat_pair_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0;
  logic        in_last = 1'b0;
  logic        in_flush = 1'b0;
  logic        pair_valid;
  logic        pair_ready = 1'b0;
  logic [15:0] pair_a;
  logic [15:0] pair_b;
  logic        pair_last;
  logic        pair_special;
  logic [2:0]  fifo_count;
  logic        err_odd;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dlfloat_pair_loader #(.DEPTH(4), .FTZ(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_flush     (in_flush),
    .pair_valid   (pair_valid),
    .pair_ready   (pair_ready),
    .pair_a       (pair_a),
    .pair_b       (pair_b),
    .pair_last    (pair_last),
    .pair_special (pair_special),
    .fifo_count   (fifo_count),
    .err_odd      (err_odd)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    #1;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    n_chk++;
    if (!in_ready) begin
      n_err++;
      $display("FAIL send_timeout data=%h in_ready=%b want 1", d, in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pop_one();
    pair_ready = 1'b1;
    tick();
    pair_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    n_chk++;
    if ({pair_valid, fifo_count, err_odd, in_ready} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outs got v=%b c=%0d e=%b r=%b want 0",
               pair_valid, fifo_count, err_odd, in_ready);
    end
    n_chk++;
    if ({pair_a, pair_b, pair_last, pair_special} !== 34'h0) begin
      n_err++;
      $display("FAIL reset_head got a=%h b=%h want 0", pair_a, pair_b);
    end
    rst = 1'b1;
    tick();
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    send_word(16'h3E00, 1'b0);
    n_chk++;
    if (pair_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_a_only got v=%b want 0", pair_valid);
    end
    send_word(16'h4000, 1'b0);
    n_chk++;
    if ({pair_valid, pair_a, pair_b, fifo_count} !==
        {1'b1, 16'h3E00, 16'h4000, 3'd1}) begin
      n_err++;
      $display("FAIL basic_pair got v=%b a=%h b=%h c=%0d want 1 3e00 4000 1",
               pair_valid, pair_a, pair_b, fifo_count);
    end
    n_chk++;
    if ({pair_last, pair_special} !== 2'b00) begin
      n_err++;
      $display("FAIL basic_tags got l=%b s=%b want 0 0",
               pair_last, pair_special);
    end
    pop_one();
    n_chk++;
    if ({pair_valid, fifo_count, pair_a} !== {1'b0, 3'd0, 16'h0}) begin
      n_err++;
      $display("FAIL basic_pop got v=%b c=%0d a=%h want 0 0 0000",
               pair_valid, fifo_count, pair_a);
    end
  endtask

  task automatic test_ftz();
    send_word(16'h0123, 1'b0);
    send_word(16'hBE00, 1'b0);
    n_chk++;
    if ({pair_a, pair_b, pair_special} !== {16'h0000, 16'hBE00, 1'b0}) begin
      n_err++;
      $display("FAIL ftz got a=%h b=%h s=%b want 0000 be00 0",
               pair_a, pair_b, pair_special);
    end
    pop_one();
    send_word(16'h8200, 1'b0);
    send_word(16'h8000, 1'b0);
    n_chk++;
    if ({pair_a, pair_b} !== {16'h8200, 16'h0000}) begin
      n_err++;
      $display("FAIL ftz_neg got a=%h b=%h want 8200 0000", pair_a, pair_b);
    end
    pop_one();
  endtask

  task automatic test_full();
    logic [15:0] ea [4] = '{16'h4200, 16'h8200, 16'h4800, 16'h4C00};
    logic [15:0] eb [4] = '{16'h4400, 16'h4600, 16'h4A00, 16'h4E00};
    send_word(16'h3E00, 1'b0);
    send_word(16'h4000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send_word(ea[i], 1'b0);
      send_word(eb[i], 1'b0);
    end
    n_chk++;
    if (fifo_count !== 3'd4) begin
      n_err++;
      $display("FAIL full_count got %0d want 4", fifo_count);
    end
    send_word(16'h4C00, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'h4E00;
    #1;
    n_chk++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_stall got in_ready=%b want 0", in_ready);
    end
    pair_ready = 1'b1;
    #1;
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL full_bypass got in_ready=%b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_chk++;
    if (fifo_count !== 3'd4) begin
      n_err++;
      $display("FAIL full_pushpop got %0d want 4", fifo_count);
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({pair_valid, pair_a, pair_b} !== {1'b1, ea[i], eb[i]}) begin
        n_err++;
        $display("FAIL full_order[%0d] got v=%b a=%h b=%h want 1 %h %h",
                 i, pair_valid, pair_a, pair_b, ea[i], eb[i]);
      end
      tick();
    end
    pair_ready = 1'b0;
    n_chk++;
    if ({pair_valid, fifo_count} !== 4'b0) begin
      n_err++;
      $display("FAIL full_drain got v=%b c=%0d want 0 0",
               pair_valid, fifo_count);
    end
  endtask

  task automatic test_odd();
    send_word(16'h3E00, 1'b1);
    n_chk++;
    if ({err_odd, fifo_count} !== {1'b1, 3'd0}) begin
      n_err++;
      $display("FAIL odd_pulse got e=%b c=%0d want 1 0", err_odd, fifo_count);
    end
    tick();
    n_chk++;
    if (err_odd !== 1'b0) begin
      n_err++;
      $display("FAIL odd_width got e=%b want 0", err_odd);
    end
    send_word(16'h4000, 1'b0);
    send_word(16'h4200, 1'b0);
    n_chk++;
    if ({fifo_count, pair_a, pair_b} !== {3'd1, 16'h4000, 16'h4200}) begin
      n_err++;
      $display("FAIL odd_realign got c=%0d a=%h b=%h want 1 4000 4200",
               fifo_count, pair_a, pair_b);
    end
    pop_one();
  endtask

  task automatic test_flush();
    send_word(16'h4400, 1'b0);
    send_word(16'h4600, 1'b0);
    send_word(16'h3E00, 1'b0);
    in_valid = 1'b1;
    in_flush = 1'b1;
    in_data  = 16'h5000;
    #1;
    n_chk++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL flush_ready got %b want 0", in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_flush = 1'b0;
    send_word(16'h4000, 1'b0);
    send_word(16'h4200, 1'b0);
    n_chk++;
    if ({fifo_count, pair_a, pair_b} !== {3'd2, 16'h4400, 16'h4600}) begin
      n_err++;
      $display("FAIL flush_keep got c=%0d a=%h b=%h want 2 4400 4600",
               fifo_count, pair_a, pair_b);
    end
    pop_one();
    n_chk++;
    if ({pair_a, pair_b} !== {16'h4000, 16'h4200}) begin
      n_err++;
      $display("FAIL flush_clean got a=%h b=%h want 4000 4200",
               pair_a, pair_b);
    end
    pop_one();
  endtask

  task automatic test_special_reset();
    send_word(16'h7FFF, 1'b0);
    send_word(16'h3E00, 1'b1);
    n_chk++;
    if ({pair_a, pair_special, pair_last, err_odd} !==
        {16'h7FFF, 1'b1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL special got a=%h s=%b l=%b e=%b want 7fff 1 1 0",
               pair_a, pair_special, pair_last, err_odd);
    end
    send_word(16'h3E00, 1'b0);
    send_word(16'hFFFF, 1'b0);
    send_word(16'h4400, 1'b0);
    n_chk++;
    if (fifo_count !== 3'd2) begin
      n_err++;
      $display("FAIL pre_reset got c=%0d want 2", fifo_count);
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if ({pair_valid, fifo_count, pair_special, pair_last} !== 6'b0) begin
      n_err++;
      $display("FAIL mid_reset got v=%b c=%0d s=%b l=%b want 0",
               pair_valid, fifo_count, pair_special, pair_last);
    end
    #3;
    rst = 1'b1;
    tick();
    send_word(16'h4600, 1'b0);
    send_word(16'h4800, 1'b0);
    n_chk++;
    if ({fifo_count, pair_a, pair_b} !== {3'd1, 16'h4600, 16'h4800}) begin
      n_err++;
      $display("FAIL reset_drop_a got c=%0d a=%h b=%h want 1 4600 4800",
               fifo_count, pair_a, pair_b);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ftz();
    test_full();
    test_odd();
    test_flush();
    test_special_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
